// File: rtl/mc_controller_v.sv
// rtl/mc_controller_v.sv - multicycle ARM-subset control FSM with NZCV flags and condition check.
// Optional `MC_PERF_CNT_EN adds CycleCount/InstrCount performance counters.
module mc_controller_v #(
  parameter int MEM_WAIT   = 0,
  parameter int ALU_CTRL_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            Cond,
  input  logic [1:0]            Op,
  input  logic [5:0]            Funct,
  input  logic [3:0]            Rd,
  input  logic [3:0]            ALUFlags,
  output logic                  PCWrite,
  output logic                  IRWrite,
  output logic                  MemWrite,
  output logic                  RegWrite,
  output logic                  AdrSrc,
  output logic [1:0]            RegSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ImmSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0]           CycleCount,
  output logic [31:0]           InstrCount
`endif
);

  if (MEM_WAIT < 0 || MEM_WAIT > 15) begin : g_mem_wait_check
    $error("mc_controller_v: MEM_WAIT must be in 0..15");
  end

  localparam logic [3:0] MEM_WAIT_C = MEM_WAIT[3:0];

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(0);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(2);
  localparam logic [ALU_CTRL_W-1:0] ALU_ORR = ALU_CTRL_W'(3);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  state_t    r_state;
  logic [3:0] r_flags;
  logic [3:0] r_wait_cnt;
  logic       r_cond_ex;

  logic                  w_cond_live;
  logic                  w_cond_ex;
  logic [3:0]            w_cmd;
  logic                  w_is_cmp;
  logic                  w_exec_arith;
  logic [ALU_CTRL_W-1:0] w_exec_ctrl;
  logic                  w_rd_pc;
  logic                  w_to_fetch;
  logic                  w_pc_we;
  logic                  w_ir_we;
  logic                  w_mem_we;
  logic                  w_reg_we;

  always_comb begin
    w_cond_live = 1'b0;
    unique case (Cond)
      4'b0000: w_cond_live = r_flags[2];
      4'b0001: w_cond_live = ~r_flags[2];
      4'b0010: w_cond_live = r_flags[1];
      4'b0011: w_cond_live = ~r_flags[1];
      4'b0100: w_cond_live = r_flags[3];
      4'b0101: w_cond_live = ~r_flags[3];
      4'b0110: w_cond_live = r_flags[0];
      4'b0111: w_cond_live = ~r_flags[0];
      4'b1000: w_cond_live = r_flags[1] & ~r_flags[2];
      4'b1001: w_cond_live = ~r_flags[1] | r_flags[2];
      4'b1010: w_cond_live = (r_flags[3] == r_flags[0]);
      4'b1011: w_cond_live = (r_flags[3] != r_flags[0]);
      4'b1100: w_cond_live = ~r_flags[2] & (r_flags[3] == r_flags[0]);
      4'b1101: w_cond_live = r_flags[2] | (r_flags[3] != r_flags[0]);
      4'b1110: w_cond_live = 1'b1;
      default: w_cond_live = 1'b0;
    endcase
  end

  // ALUWB must see the condition as it stood before its own EXEC flag update.
  assign w_cond_ex = (r_state == S_ALUWB) ? r_cond_ex : w_cond_live;

  assign w_cmd    = Funct[4:1];
  assign w_is_cmp = (w_cmd == 4'b1010);
  assign w_rd_pc  = (Rd == 4'hF);

  always_comb begin
    w_exec_ctrl = ALU_ADD;
    case (w_cmd)
      4'b0100: w_exec_ctrl = ALU_ADD;
      4'b0010: w_exec_ctrl = ALU_SUB;
      4'b0000: w_exec_ctrl = ALU_AND;
      4'b1100: w_exec_ctrl = ALU_ORR;
      4'b1010: w_exec_ctrl = ALU_SUB;
      default: w_exec_ctrl = ALU_ADD;
    endcase
  end

  assign w_exec_arith = (w_exec_ctrl == ALU_ADD) || (w_exec_ctrl == ALU_SUB);

  assign w_to_fetch = ((r_state == S_DECODE) && (Op == 2'b11)) ||
                      ((r_state == S_MEMWRITE) && (r_wait_cnt == 4'd0)) ||
                      (((r_state == S_EXECR) || (r_state == S_EXECI)) && w_is_cmp) ||
                      (r_state == S_MEMWB) || (r_state == S_ALUWB) || (r_state == S_BRANCH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_FETCH;
      r_flags    <= 4'b0000;
      r_wait_cnt <= 4'd0;
      r_cond_ex  <= 1'b0;
    end else begin
      r_cond_ex <= w_cond_live;
      case (r_state)
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          case (Op)
            2'b01:   r_state <= S_MEMADR;
            2'b00:   r_state <= Funct[5] ? S_EXECI : S_EXECR;
            2'b10:   r_state <= S_BRANCH;
            default: r_state <= S_FETCH;
          endcase
        end
        S_MEMADR: begin
          r_wait_cnt <= MEM_WAIT_C;
          r_state    <= Funct[0] ? S_MEMREAD : S_MEMWRITE;
        end
        S_MEMREAD: begin
          if (r_wait_cnt != 4'd0) r_wait_cnt <= r_wait_cnt - 4'd1;
          else                    r_state    <= S_MEMWB;
        end
        S_MEMWRITE: begin
          if (r_wait_cnt != 4'd0) r_wait_cnt <= r_wait_cnt - 4'd1;
          else                    r_state    <= S_FETCH;
        end
        S_EXECR, S_EXECI: begin
          if (Funct[0] && w_cond_live) begin
            r_flags[3:2] <= ALUFlags[3:2];
            if (w_exec_arith) r_flags[1:0] <= ALUFlags[1:0];
          end
          r_state <= w_is_cmp ? S_FETCH : S_ALUWB;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    w_pc_we    = 1'b0;
    w_ir_we    = 1'b0;
    w_mem_we   = 1'b0;
    w_reg_we   = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'd0;
    ALUSrcB    = 2'd0;
    ResultSrc  = 2'd0;
    ALUControl = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_ir_we   = 1'b1;
        w_pc_we   = 1'b1;
        ALUSrcA   = 2'd1;
        ALUSrcB   = 2'd2;
        ResultSrc = 2'd2;
      end
      S_DECODE: begin
        ALUSrcA   = 2'd1;
        ALUSrcB   = 2'd2;
        ResultSrc = 2'd2;
      end
      S_MEMADR: begin
        ALUSrcB    = 2'd1;
        ALUControl = Funct[3] ? ALU_ADD : ALU_SUB;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'd1;
        w_reg_we  = w_cond_ex;
        w_pc_we   = w_cond_ex & w_rd_pc;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        w_mem_we = w_cond_ex & (r_wait_cnt == 4'd0);
      end
      S_EXECR: ALUControl = w_exec_ctrl;
      S_EXECI: begin
        ALUSrcB    = 2'd1;
        ALUControl = w_exec_ctrl;
      end
      S_ALUWB: begin
        w_reg_we = w_cond_ex;
        w_pc_we  = w_cond_ex & w_rd_pc;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'd1;
        ResultSrc = 2'd2;
        w_pc_we   = w_cond_ex;
      end
      default: ;
    endcase
  end

  // Enables are forced low for the whole time reset is held, not just at the edge.
  assign PCWrite  = w_pc_we & reset;
  assign IRWrite  = w_ir_we & reset;
  assign MemWrite = w_mem_we & reset;
  assign RegWrite = w_reg_we & reset;
  assign RegSrc   = {(Op == 2'b01), (Op == 2'b10)};
  assign ImmSrc   = Op;

`ifdef MC_PERF_CNT_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instr_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle_cnt <= 32'd0;
      r_instr_cnt <= 32'd0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_to_fetch) r_instr_cnt <= r_instr_cnt + 32'd1;
    end
  end

  assign CycleCount = r_cycle_cnt;
  assign InstrCount = r_instr_cnt;
`else
  logic w_unused_perf;
  assign w_unused_perf = w_to_fetch;
`endif

endmodule

// File: tb/tb_mc_controller_v.sv
// tb/tb_mc_controller_v.sv - directed-vector bench for mc_controller_v (MEM_WAIT=2).
module tb_mc_controller_v;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic [3:0]  alu_flags;

  logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc;
  logic [1:0] RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0] ALUControl;
`ifdef MC_PERF_CNT_EN
  logic [31:0] CycleCount, InstrCount;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int exp_instr = 0;

  mc_controller_v #(.MEM_WAIT(2), .ALU_CTRL_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .Cond       (instr[31:28]),
    .Op         (instr[27:26]),
    .Funct      (instr[25:20]),
    .Rd         (instr[15:12]),
    .ALUFlags   (alu_flags),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .AdrSrc     (AdrSrc),
    .RegSrc     (RegSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl)
`ifdef MC_PERF_CNT_EN
    ,
    .CycleCount (CycleCount),
    .InstrCount (InstrCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCWrite,IRWrite,MemWrite,RegWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}
  logic [13:0] obs;
  assign obs = {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl};

  localparam logic [13:0] V_FETCH    = 14'b1100_0_01_10_10_000;
  localparam logic [13:0] V_RST      = 14'b0000_0_01_10_10_000;
  localparam logic [13:0] V_DECODE   = 14'b0000_0_01_10_10_000;
  localparam logic [13:0] V_EXEC_ADD = 14'b0000_0_00_00_00_000;
  localparam logic [13:0] V_EXEC_SUB = 14'b0000_0_00_00_00_001;
  localparam logic [13:0] V_ALUWB    = 14'b0001_0_00_00_00_000;
  localparam logic [13:0] V_MEMADR   = 14'b0000_0_00_01_00_000;
  localparam logic [13:0] V_MEMRD    = 14'b0000_1_00_00_00_000;
  localparam logic [13:0] V_MEMWB    = 14'b0001_0_00_00_01_000;
  localparam logic [13:0] V_MEMWR_ON = 14'b0010_1_00_00_00_000;
  localparam logic [13:0] V_BR_TAKEN = 14'b1000_0_00_01_10_000;
  localparam logic [13:0] V_BR_NOT   = 14'b0000_0_00_01_10_000;

  task automatic test_reset();
    reset = 1'b0;
    instr = 32'hE0821003;
    alu_flags = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (obs !== V_RST) begin
        tests_failed++;
        $display("FAIL reset_hold cyc%0d obs=%b exp=%b", i, obs, V_RST);
      end
    end
`ifdef MC_PERF_CNT_EN
    tests_run++;
    if (CycleCount !== 32'd0 || InstrCount !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_perf cyc=%0d ins=%0d exp=0/0", CycleCount, InstrCount);
    end
`endif
    reset = 1'b1;
    #1;
    tests_run++;
    if (obs !== V_FETCH) begin
      tests_failed++;
      $display("FAIL reset_release obs=%b exp=%b", obs, V_FETCH);
    end
  endtask

  task automatic test_add();
    logic [13:0] exp_q[$];
    exp_q = '{V_DECODE, V_EXEC_ADD, V_ALUWB, V_FETCH};
    instr = 32'hE0821003;
    alu_flags = 4'b0100;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      tests_run++;
      if (obs !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL add cyc%0d obs=%b exp=%b", i + 2, obs, exp_q[i]);
      end
    end
    exp_instr++;
`ifdef MC_PERF_CNT_EN
    tests_run++;
    if (CycleCount !== 32'd4 || InstrCount !== 32'd1) begin
      tests_failed++;
      $display("FAIL add_perf cyc=%0d ins=%0d exp=4/1", CycleCount, InstrCount);
    end
`endif
  endtask

  task automatic test_ldr();
    logic [13:0] exp_q[$];
    exp_q = '{V_DECODE, V_MEMADR, V_MEMRD, V_MEMRD, V_MEMRD, V_MEMWB, V_FETCH};
    instr = 32'hE5921004;
    alu_flags = 4'b1111;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      tests_run++;
      if (obs !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL ldr cyc%0d obs=%b exp=%b", i + 2, obs, exp_q[i]);
      end
    end
    exp_instr++;
  endtask

  task automatic test_branch(input logic [31:0] ins, input logic taken, input string name);
    logic [13:0] exp_q[$];
    exp_q = '{V_DECODE, taken ? V_BR_TAKEN : V_BR_NOT, V_FETCH};
    instr = ins;
    alu_flags = 4'b0000;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      tests_run++;
      if (obs !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL %s cyc%0d obs=%b exp=%b", name, i + 2, obs, exp_q[i]);
      end
    end
    exp_instr++;
  endtask

  task automatic test_cmp();
    logic [13:0] exp_q[$];
    exp_q = '{V_DECODE, V_EXEC_SUB, V_FETCH};
    instr = 32'hE1510001;
    alu_flags = 4'b0100;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      tests_run++;
      if (obs !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL cmp cyc%0d obs=%b exp=%b", i + 2, obs, exp_q[i]);
      end
    end
    exp_instr++;
  endtask

  // ADDSEQ with S: clears Z in EXECR, yet ALUWB still writes
  task automatic test_cond_sample();
    logic [13:0] exp_q[$];
    exp_q = '{V_DECODE, V_EXEC_ADD, V_ALUWB, V_FETCH};
    instr = 32'h00912003;
    alu_flags = 4'b0000;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      tests_run++;
      if (obs !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL cond_sample cyc%0d obs=%b exp=%b", i + 2, obs, exp_q[i]);
      end
    end
    exp_instr++;
  endtask

  task automatic test_nop();
    logic [13:0] exp_q[$];
    exp_q = '{V_DECODE, V_FETCH};
    instr = 32'hEC000000;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      tests_run++;
      if (obs !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL nop cyc%0d obs=%b exp=%b", i + 2, obs, exp_q[i]);
      end
    end
    exp_instr++;
  endtask

  task automatic test_str();
    logic [13:0] exp_q[$];
    exp_q = '{V_DECODE, V_MEMADR, V_MEMRD, V_MEMRD, V_MEMWR_ON, V_FETCH};
    instr = 32'hE5821004;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      tests_run++;
      if (obs !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL str cyc%0d obs=%b exp=%b", i + 2, obs, exp_q[i]);
      end
    end
    exp_instr++;
`ifdef MC_PERF_CNT_EN
    tests_run++;
    if (InstrCount !== 32'(exp_instr)) begin
      tests_failed++;
      $display("FAIL instr_count got=%0d exp=%0d", InstrCount, exp_instr);
    end
`endif
  endtask

  task automatic test_reset_mid_write();
    logic [13:0] exp_q[$];
    exp_q = '{V_DECODE, V_MEMADR, V_MEMRD, V_MEMRD};
    instr = 32'hE5821004;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      tests_run++;
      if (obs !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL rst_mid cyc%0d obs=%b exp=%b", i + 2, obs, exp_q[i]);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (obs !== V_RST) begin
        tests_failed++;
        $display("FAIL rst_mid_hold step%0d obs=%b exp=%b", i, obs, V_RST);
      end
      @(negedge clk);
    end
`ifdef MC_PERF_CNT_EN
    tests_run++;
    if (CycleCount !== 32'd0 || InstrCount !== 32'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_perf cyc=%0d ins=%0d exp=0/0", CycleCount, InstrCount);
    end
`endif
    reset = 1'b1;
    #1;
    tests_run++;
    if (obs !== V_FETCH) begin
      tests_failed++;
      $display("FAIL rst_mid_release obs=%b exp=%b", obs, V_FETCH);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldr();
    test_branch(32'h0A000002, 1'b0, "beq_z0");
    test_cmp();
    test_branch(32'h0A000002, 1'b1, "beq_z1");
    test_branch(32'hFA000002, 1'b0, "bnv");
    test_cond_sample();
    test_branch(32'h0A000002, 1'b0, "beq_after_s");
    test_nop();
    test_str();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mc_controller_v.md
Name: mc_controller_v

Overview:
- Multicycle control unit for the ARM-subset datapath; one instruction takes 3–5+ cycles through a shared ALU/memory.
- Decodes the latched instruction fields and sequences the datapath write enables and mux selects.
- Holds the NZCV flags register and evaluates the condition field.
- Sits beside the multicycle datapath and drives all of its control inputs.

Parameters:
- MEM_WAIT, 0: extra wait cycles inserted in MEMREAD and MEMWRITE (0–15).
- ALU_CTRL_W, 3: width of ALUControl.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- Cond  in  4  Instr[31:28]
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]
- Rd  in  4  Instr[15:12]
- ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle
- PCWrite  out  1  PC register enable
- IRWrite  out  1  instruction register enable
- MemWrite  out  1  data memory write strobe
- RegWrite  out  1  register file write enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUResult register
- RegSrc  out  2  register read-address selects: [0]=RA1 is R15, [1]=RA2 is Rd
- ALUSrcA  out  2  0=register A, 1=PC
- ALUSrcB  out  2  0=register B, 1=ExtImm, 2=constant 4
- ResultSrc  out  2  0=ALUOut register, 1=Data register, 2=ALUResult
- ImmSrc  out  2  equals Op
- ALUControl  out  ALU_CTRL_W  000 ADD, 001 SUB, 010 AND, 011 ORR

Behaviour:
- Reset asserted (low):
  - State goes to FETCH and Flags to 0000; wait counter cleared.
  - All write enables (PCWrite, IRWrite, MemWrite, RegWrite) held at 0 regardless of state.
  - Mux selects take their FETCH values.
  - Same behaviour when reset is asserted mid-instruction: the instruction is abandoned with no writes.
- First rising edge after deassertion executes FETCH.
- Condition check (CondEx): standard ARM codes 0000 EQ through 1110 AL, evaluated against the Flags register. 1111 counts as never.
- State encoding and outputs are Moore except write enables, which are gated by CondEx as noted.

States:
- FETCH:
  - Outputs: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=2, ResultSrc=2, ADD.
  - Next: DECODE.
- DECODE:
  - Outputs: ALUSrcA=1, ALUSrcB=2, ResultSrc=2, ADD (forms PC+8).
  - Next: Op=01 → MEMADR; Op=00 with Funct[5]=0 → EXECR; Op=00 with Funct[5]=1 → EXECI; Op=10 → BRANCH; Op=11 → FETCH (NOP).
- MEMADR:
  - Outputs: ALUSrcA=0, ALUSrcB=1; ADD if Funct[3] (U bit) =1, else SUB.
  - Next: Funct[0]=1 → MEMREAD, else MEMWRITE. Counter loaded with MEM_WAIT.
- MEMREAD:
  - Outputs: AdrSrc=1.
  - Stays while counter≠0, decrementing each cycle; then MEMWB.
- MEMWB:
  - Outputs: ResultSrc=1, RegWrite=CondEx.
  - If Rd=15, PCWrite=CondEx.
  - Next: FETCH.
- MEMWRITE:
  - Outputs: AdrSrc=1.
  - MemWrite=CondEx only in the cycle where counter=0; then FETCH.
- EXECR / EXECI:
  - Outputs: ALUSrcA=0; ALUSrcB=0 (EXECR) or 1 (EXECI).
  - Cmd=Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB, no writeback); other codes ADD.
  - Flags updated at the end of the cycle if Funct[0]=1 and CondEx: NZ always; CV only for ADD/SUB/CMP.
  - Next: CMP → FETCH, else ALUWB.
- ALUWB:
  - Outputs: ResultSrc=0, RegWrite=CondEx.
  - If Rd=15, PCWrite=CondEx.
  - Next: FETCH.
- BRANCH:
  - Outputs: ALUSrcA=0, ALUSrcB=1, ResultSrc=2, ADD, PCWrite=CondEx.
  - Next: FETCH.

Timing and boundary rules:
- CondEx is sampled from the Flags value at the start of the cycle; a flag update in EXECR does not affect that same instruction's ALUWB gating.
- Latency with MEM_WAIT=0: ALU op = 4 cycles, CMP = 3, branch = 3, LDR = 5, STR = 4. Memory ops add MEM_WAIT cycles.
- Counter is 4-bit; MEM_WAIT > 15 is a parameter error (elaboration `$error`).

Optional Feature:
- Macro: MC_PERF_CNT_EN.
- When defined, adds outputs CycleCount[31:0] and InstrCount[31:0], both reset to 0.
  - CycleCount increments every cycle while reset is high.
  - InstrCount increments on every transition into FETCH from a non-FETCH state, including condition-failed and NOP instructions.
  - Both wrap from 0xFFFFFFFF to 0.
- When undefined, these ports and registers are absent.

Test Plan:
- Reset low for 3 cycles, then release → all write enables 0 during reset; cycle 1 after release: IRWrite=1, PCWrite=1, Flags=0000.
- Instr 0xE0821003 (ADD R1,R2,R3) → states FETCH, DECODE, EXECR, ALUWB; ALUControl=000; RegWrite=1 only in ALUWB; back to FETCH on cycle 5.
- MEM_WAIT=2, Instr 0xE5921004 (LDR) → MEMREAD lasts 3 cycles, AdrSrc=1; RegWrite=1 in MEMWB; 7 cycles total.
- Instr 0xE1510001 (CMP) with ALUFlags=0100 → Flags=0100 after EXECR; no RegWrite; back to FETCH after 3 cycles.
- Flags Z=0, Instr 0x0A000002 (BEQ) → PCWrite=0 in BRANCH. With Z=1 → PCWrite=1.
- Reset asserted during MEMWRITE with counter=1 → MemWrite never pulses; state=FETCH on release; with MC_PERF_CNT_EN, both counters read 0.
